// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the main-memory port arbiter and the memory
// interface units that sit in front of it.
package mem_port_arbiter_pkg;

  localparam int MEM_ADDR_W = 14;
  localparam int MEM_DATA_W = 16;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_RESP
  } arb_state_t;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of the shared memory port.
// The arbiter takes the slave view; the requesters plus memory take the master view.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
);

  logic [N_REQ-1:0]        rq_read;
  logic [N_REQ-1:0]        rq_write;
  logic [N_REQ*ADDR_W-1:0] rq_addr;
  logic [N_REQ*DATA_W-1:0] rq_wdata;
  logic [N_REQ-1:0]        rq_done;
  logic [N_REQ-1:0]        rq_err;
  logic [DATA_W-1:0]       rq_rdata;

  logic                    cs;
  logic                    read_req;
  logic                    write_req;
  logic [ADDR_W-1:0]       addrout;
  logic [DATA_W-1:0]       datatomem;
  logic [DATA_W-1:0]       datafrommem;
  logic                    mem_resp;

  modport slave (
    input  rq_read, rq_write, rq_addr, rq_wdata, datafrommem, mem_resp,
    output rq_done, rq_err, rq_rdata, cs, read_req, write_req, addrout, datatomem
  );

  modport master (
    output rq_read, rq_write, rq_addr, rq_wdata, datafrommem, mem_resp,
    input  rq_done, rq_err, rq_rdata, cs, read_req, write_req, addrout, datatomem
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin selector: first pending requester at or after
// the pointer, wrapping modulo N_REQ.
module mem_port_arbiter_rr_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IW    = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] pending_i,
  input  logic [IW-1:0]    ptr_i,
  output logic             found_o,
  output logic [IW-1:0]    idx_o
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  always_comb begin
    // NOTE: every output gets a value before any branch so no latch is inferred.
    found_o = 1'b0;
    idx_o   = '0;
    sum     = '0;
    cand    = '0;
    // Walk offsets from farthest to nearest so the nearest pending one wins.
    for (int off = N_REQ - 1; off >= 0; off--) begin
      sum = {1'b0, ptr_i} + (IW + 1)'(off);
      if (sum >= (IW + 1)'(N_REQ)) begin
        sum = sum - (IW + 1)'(N_REQ);
      end
      cand = sum[IW-1:0];
      if (pending_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between N_REQ requesters: round-robin grant,
// one transaction in flight, per-transaction timeout, all outputs registered.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int TMO_CYC = 255
) (
  input  logic           clk,
  input  logic           reset_n,
  mem_port_arbiter_if.slave bus
);

  localparam int IW = idx_width(N_REQ);
  localparam int TW = $clog2(TMO_CYC + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

  arb_state_t        state_q, state_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              cs_q, cs_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [N_REQ-1:0]  err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              pick_found;
  logic [IW-1:0]     pick_idx;
  logic              pick_rd, pick_wr;
  logic [ADDR_W-1:0] pick_addr;
  logic [DATA_W-1:0] pick_wdata;

  mem_port_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .pending_i (bus.rq_read | bus.rq_write),
    .ptr_i     (ptr_q),
    .found_o   (pick_found),
    .idx_o     (pick_idx)
  );

  // Mux out the chosen requester's request fields with constant slice bases.
  always_comb begin
    pick_rd    = 1'b0;
    pick_wr    = 1'b0;
    pick_addr  = '0;
    pick_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IW'(i)) begin
        pick_rd    = bus.rq_read[i];
        pick_wr    = bus.rq_write[i];
        pick_addr  = bus.rq_addr[i*ADDR_W +: ADDR_W];
        pick_wdata = bus.rq_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cs_d    = cs_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    tmo_d   = tmo_q;
    rdata_d = rdata_q;
    done_d  = '0;
    err_d   = '0;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          addr_d  = pick_addr;
          wdata_d = pick_wdata;
          if (pick_rd && pick_wr) begin
            // Conflicting direction: complete with error, memory never touched.
            done_d[pick_idx] = 1'b1;
            err_d[pick_idx]  = 1'b1;
            state_d          = ARB_RESP;
          end else begin
            cs_d    = 1'b1;
            rd_d    = pick_rd;
            wr_d    = pick_wr;
            tmo_d   = '0;
            state_d = ARB_ACCESS;
          end
        end
      end

      ARB_ACCESS: begin
        // mem_resp takes precedence over a timeout expiring in the same cycle.
        if (bus.mem_resp || (tmo_q == TMO_LAST)) begin
          cs_d            = 1'b0;
          rd_d            = 1'b0;
          wr_d            = 1'b0;
          done_d[grant_q] = 1'b1;
          err_d[grant_q]  = ~bus.mem_resp;
          if (bus.mem_resp && rd_q) begin
            rdata_d = bus.datafrommem;
          end
          state_d = ARB_RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ARB_RESP: begin
        ptr_d   = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
        state_d = ARB_IDLE;
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: data registers are reset as well, because they drive outputs that must read 0.
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cs_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      tmo_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.cs        = cs_q;
  assign bus.read_req  = rd_q;
  assign bus.write_req = wr_q;
  assign bus.addrout   = addr_q;
  assign bus.datatomem = wdata_q;
  assign bus.rq_done   = done_q;
  assign bus.rq_err    = err_q;
  assign bus.rq_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table of request patterns with a
// completion scoreboard and a memory model that checks every access it sees.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int N_REQ   = 2;
  localparam int ADDR_W  = MEM_ADDR_W;
  localparam int DATA_W  = MEM_DATA_W;
  localparam int TMO_CYC = 8;
  localparam int N_VEC   = 9;

  typedef struct {
    int                idx;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } done_exp_t;

  typedef struct {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int                len;   // expected cs-high cycles, 0 = don't care
  } acc_exp_t;

  typedef struct {
    logic [N_REQ-1:0]        rd;
    logic [N_REQ-1:0]        wr;
    logic [N_REQ*ADDR_W-1:0] addr;
    logic [N_REQ*DATA_W-1:0] wdata;
    int                      lat;  // cycles after cs before mem_resp, -1 = never
    logic [DATA_W-1:0]       md;
  } vec_t;

  logic clk;
  logic reset_n;

  mem_port_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .N_REQ   (N_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TMO_CYC (TMO_CYC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  done_exp_t         sb_q[$];
  acc_exp_t          acc_q[$];
  int                n_checks = 0;
  int                n_fail   = 0;
  int                exp_ptr;
  logic [DATA_W-1:0] exp_rdata;
  int                cur_lat;
  logic [DATA_W-1:0] cur_md;
  vec_t              vecs[N_VEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: grant order from the pointer, expected completions and accesses.
  task automatic push_expected(input vec_t v);
    int last;
    last = -1;
    for (int k = 0; k < N_REQ; k++) begin
      int i;
      done_exp_t d;
      acc_exp_t a;
      logic bad;
      i = (exp_ptr + k) % N_REQ;
      if (v.rd[i] || v.wr[i]) begin
        bad   = v.rd[i] && v.wr[i];
        d.idx = i;
        d.err = bad || (v.lat < 0);
        if (!bad && v.rd[i] && v.lat >= 0) exp_rdata = v.md;
        d.rdata = exp_rdata;
        sb_q.push_back(d);
        if (!bad) begin
          a.rd    = v.rd[i];
          a.wr    = v.wr[i];
          a.addr  = v.addr[i*ADDR_W +: ADDR_W];
          a.wdata = v.wdata[i*DATA_W +: DATA_W];
          a.len   = (v.lat < 0) ? TMO_CYC : v.lat + 1;
          acc_q.push_back(a);
        end
        last = i;
      end
    end
    if (last >= 0) exp_ptr = (last + 1) % N_REQ;
  endtask

  // Requester behaviour: drop a request right after its rq_done.
  task automatic wait_done(input int n);
    int left;
    int budget;
    left   = n;
    budget = 200;
    while (left > 0 && budget > 0) begin
      @(posedge clk); #2;
      for (int i = 0; i < N_REQ; i++) begin
        if (bus.rq_done[i]) begin
          bus.rq_read[i]  = 1'b0;
          bus.rq_write[i] = 1'b0;
          left--;
        end
      end
      budget--;
    end
    check("all_done_in_budget", left, 0);
  endtask

  task automatic run_vec(input vec_t v);
    @(posedge clk); #2;
    cur_lat = v.lat;
    cur_md  = v.md;
    push_expected(v);
    bus.rq_addr  = v.addr;
    bus.rq_wdata = v.wdata;
    bus.rq_read  = v.rd;
    bus.rq_write = v.wr;
    wait_done($countones(v.rd | v.wr));
    repeat (2) @(posedge clk);
  endtask

  // Completion scoreboard.
  initial begin
    done_exp_t e;
    forever begin
      @(posedge clk); #2;
      for (int i = 0; i < N_REQ; i++) begin
        if (bus.rq_done[i]) begin
          if (sb_q.size() == 0) begin
            check("unexpected_done", 32'(bus.rq_done), 32'd0);
          end else begin
            e = sb_q.pop_front();
            check("done_idx", i, e.idx);
            check("done_err", 32'(bus.rq_err[i]), 32'(e.err));
            check("done_rdata", 32'(bus.rq_rdata), 32'(e.rdata));
          end
        end
      end
    end
  end

  // Memory model: responds after cur_lat cycles and checks each access.
  initial begin
    int                         cyc;
    logic                       active;
    logic                       stable;
    logic [ADDR_W+DATA_W+1:0]   snap;
    acc_exp_t                   a;
    active          = 1'b0;
    cyc             = 0;
    stable          = 1'b1;
    snap            = '0;
    a.len           = 0;
    bus.mem_resp    = 1'b0;
    bus.datafrommem = 16'hDEAD;
    forever begin
      @(posedge clk); #1;
      if (bus.cs) begin
        if (!active) begin
          active = 1'b1;
          cyc    = 0;
          stable = 1'b1;
          snap   = {bus.read_req, bus.write_req, bus.addrout, bus.datatomem};
          if (acc_q.size() == 0) begin
            check("unexpected_cs", 32'(bus.cs), 32'd0);
            a.len = 0;
          end else begin
            a = acc_q.pop_front();
            check("acc_dir", 32'({bus.read_req, bus.write_req}), 32'({a.rd, a.wr}));
            check("acc_addr", 32'(bus.addrout), 32'(a.addr));
            if (a.wr) check("acc_wdata", 32'(bus.datatomem), 32'(a.wdata));
          end
        end else if (snap !== {bus.read_req, bus.write_req, bus.addrout, bus.datatomem}) begin
          stable = 1'b0;
        end
        if (cyc == cur_lat) begin
          bus.mem_resp    = 1'b1;
          bus.datafrommem = cur_md;
        end else begin
          bus.mem_resp    = 1'b0;
          bus.datafrommem = 16'hDEAD;
        end
        cyc++;
      end else begin
        if (active) begin
          active = 1'b0;
          check("acc_stable", 32'(stable), 32'd1);
          if (a.len > 0) check("acc_len", cyc, a.len);
        end
        bus.mem_resp    = 1'b0;
        bus.datafrommem = 16'hDEAD;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    int   budget;

    bus.rq_read  = '0;
    bus.rq_write = '0;
    bus.rq_addr  = '0;
    bus.rq_wdata = '0;
    exp_ptr      = 0;
    exp_rdata    = '0;
    cur_lat      = 0;
    cur_md       = '0;

    //          rd     wr     addr {r1,r0}              wdata {r1,r0}             lat  md
    vecs[0] = '{2'b00, 2'b10, {14'h0200, 14'h0000}, {16'h5A5A, 16'h0000}, 2,  16'h7777};
    vecs[1] = '{2'b10, 2'b01, {14'h0020, 14'h0010}, {16'h0000, 16'h1111}, 0,  16'h2222};
    vecs[2] = '{2'b01, 2'b00, {14'h0000, 14'h3FFF}, {16'h0000, 16'h0000}, 1,  16'hFFFF};
    vecs[3] = '{2'b10, 2'b01, {14'h0020, 14'h0010}, {16'h0000, 16'h1111}, 0,  16'h3333};
    vecs[4] = '{2'b10, 2'b00, {14'h0055, 14'h0000}, {16'h0000, 16'h0000}, -1, 16'h9999};
    vecs[5] = '{2'b01, 2'b01, {14'h0000, 14'h0033}, {16'h0000, 16'hABCD}, 0,  16'h8888};
    vecs[6] = '{2'b10, 2'b00, {14'h1234, 14'h0000}, {16'h0000, 16'h0000}, TMO_CYC - 1, 16'h0A0A};
    vecs[7] = '{2'b11, 2'b10, {14'h0099, 14'h0042}, {16'h0000, 16'h0000}, 0,  16'h4444};
    vecs[8] = '{2'b00, 2'b11, {14'h0101, 14'h0100}, {16'h5555, 16'hAAAA}, 3,  16'h6666};

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_strobes", 32'({bus.cs, bus.read_req, bus.write_req}), 32'd0);
    check("rst_addrout", 32'(bus.addrout), 32'd0);
    check("rst_datatomem", 32'(bus.datatomem), 32'd0);
    check("rst_done_err", 32'({bus.rq_done, bus.rq_err}), 32'd0);
    check("rst_rdata", 32'(bus.rq_rdata), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single read with exact latency: strobes after edge 1, rq_done after edge 2.
    @(posedge clk); #2;
    v = '{2'b01, 2'b00, {14'h0000, 14'h0123}, {16'h0000, 16'h0000}, 0, 16'hBEEF};
    cur_lat = v.lat;
    cur_md  = v.md;
    push_expected(v);
    bus.rq_addr = v.addr;
    bus.rq_read = v.rd;
    @(posedge clk); #3;
    check("lat_strobes_e1", 32'({bus.cs, bus.read_req, bus.write_req}), 32'b110);
    check("lat_addr_e1", 32'(bus.addrout), 32'h0123);
    check("lat_no_done_e1", 32'(bus.rq_done), 32'd0);
    @(posedge clk); #3;
    check("lat_done_e2", 32'(bus.rq_done), 32'b01);
    check("lat_cs_low_e2", 32'(bus.cs), 32'd0);
    bus.rq_read = '0;
    repeat (3) @(posedge clk);

    for (int n = 0; n < N_VEC; n++) begin
      run_vec(vecs[n]);
    end

    // Asynchronous reset in the middle of a write that never completes.
    @(posedge clk); #2;
    cur_lat = -1;
    cur_md  = '0;
    acc_q.push_back('{1'b0, 1'b1, 14'h0777, 16'hC0DE, 0});
    bus.rq_addr  = {14'h0000, 14'h0777};
    bus.rq_wdata = {16'h0000, 16'hC0DE};
    bus.rq_write = 2'b01;
    budget = 10;
    do begin
      @(posedge clk); #2;
      budget--;
    end while (!bus.cs && budget > 0);
    check("rst_mid_cs_before", 32'({bus.cs, bus.write_req}), 32'b11);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("rst_mid_async_drop", 32'({bus.cs, bus.write_req}), 32'b00);
    check("rst_mid_no_done", 32'(bus.rq_done), 32'd0);
    bus.rq_write = '0;
    exp_ptr      = 0;
    exp_rdata    = '0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_mid_rdata_cleared", 32'(bus.rq_rdata), 32'd0);

    // After reset requester 0 has priority again.
    run_vec('{2'b11, 2'b00, {14'h0022, 14'h0011}, {16'h0000, 16'h0000}, 0, 16'h5151});

    repeat (4) @(posedge clk);
    #2;
    check("sb_empty", sb_q.size(), 0);
    check("acc_empty", acc_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
